// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer: FSM encoding, counter mode
// values and the default counter width.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic MODO_COUNT = 1'b0;
  localparam logic MODO_LOAD  = 1'b1;

  localparam int unsigned CNT_W_DEFAULT = 4;

endpackage

// File: rtl/counter_seq_arb.sv
// Combinational request-to-one-hot arbiter. With COUNTER_SEQ_ROUND_ROBIN_EN the search
// starts one past ptr; otherwise the lowest requesting index wins and ptr is ignored.
module counter_seq_arb #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

`ifdef COUNTER_SEQ_ROUND_ROBIN_EN
  always_comb begin
    int unsigned cand;
    cand  = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = (32'(ptr) + 1 + off) % N_REQ;
      if (!valid && req[IDX_W'(cand)]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!valid && req[IDX_W'(i)]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end
`endif

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer/arbiter driving a shared loadable counter: grant, load start, count to stop,
// pulse done. COUNTER_SEQ_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] start_val,
  input  logic [N_REQ*CNT_W-1:0] stop_val,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   cnt_enb,
  output logic                   cnt_modo,
  output logic [CNT_W-1:0]       cnt_data,
  input  logic [CNT_W-1:0]       cnt_q
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] stop_q, stop_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic [IDX_W-1:0] ptr;
  logic             ptr_upd;
  logic             win_req;
  logic             run_hit;

  counter_seq_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign win_req = req[win_q];
  assign run_hit = (cnt_q == stop_q);

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    data_d   = data_q;
    stop_d   = stop_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    cnt_enb  = 1'b0;
    cnt_modo = MODO_COUNT;
    ptr_upd  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          win_d   = arb_idx;
          data_d  = start_val[arb_idx*CNT_W +: CNT_W];
          stop_d  = stop_val[arb_idx*CNT_W +: CNT_W];
          gnt_d   = arb_gnt;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_modo = MODO_LOAD;
        if (!win_req) begin
          gnt_d   = '0;
          ptr_upd = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_enb = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        // A dropped request wins over reaching the stop value: abort, no done pulse.
        if (!win_req) begin
          gnt_d   = '0;
          ptr_upd = 1'b1;
          state_d = StIdle;
        end else if (run_hit) begin
          done_d  = gnt_q;
          state_d = StDone;
        end else begin
          cnt_enb = 1'b1;
        end
      end
      StDone: begin
        gnt_d   = '0;
        ptr_upd = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      win_q   <= '0;
      data_q  <= '0;
      stop_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      data_q  <= data_d;
      stop_q  <= stop_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

`ifdef COUNTER_SEQ_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q;

  // Reset to the last index so the first search starts at requester 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= IDX_W'(N_REQ - 1);
    end else if (ptr_upd) begin
      ptr_q <= win_q;
    end
  end

  assign ptr = ptr_q;
`else
  logic unused_ptr_upd;
  assign unused_ptr_upd = ptr_upd;
  assign ptr            = '0;
`endif

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = (state_q != StIdle);
  assign cnt_data = data_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Randomized scoreboard bench for counter_seq_ctrl with a behavioural counter and a
// transaction-level reference model; honours COUNTER_SEQ_ROUND_ROBIN_EN.
module tb_counter_seq_ctrl;
  import counter_seq_pkg::*;

  localparam int unsigned N    = 2;
  localparam int unsigned W    = 4;
  localparam int unsigned SV_W = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [SV_W-1:0] start_val, stop_val;
  logic [N-1:0]  gnt, done;
  logic          busy, cnt_enb, cnt_modo;
  logic [W-1:0]  cnt_data, cnt_q;

  always #5 clk = ~clk;

  counter_seq_ctrl #(
    .N_REQ (N),
    .CNT_W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .start_val (start_val),
    .stop_val  (stop_val),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .cnt_enb   (cnt_enb),
    .cnt_modo  (cnt_modo),
    .cnt_data  (cnt_data),
    .cnt_q     (cnt_q)
  );

  // Counter datapath stand-in
  logic [W-1:0] ctr = '0;
  always @(posedge clk) if (cnt_enb) ctr <= (cnt_modo == MODO_LOAD) ? cnt_data : ctr + 1'b1;
  assign cnt_q = ctr;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned  w;
    logic [W-1:0] stop;
    int unsigned  cyc;
  } exp_t;
  exp_t sb[$];

  // Reference model: one transaction at a time, described by grant cycle t and length k.
  bit           started = 0;
  bit           m_act   = 0;
  int unsigned  m_w, m_t, m_k;
  int unsigned  m_free  = 0;
  int unsigned  m_last  = N - 1;
  logic [W-1:0] m_start;
  logic [W-1:0] m_data  = '0;

  function automatic int unsigned pick(input logic [N-1:0] r, input int unsigned last);
`ifdef COUNTER_SEQ_ROUND_ROBIN_EN
    for (int unsigned off = 0; off < N; off++) begin
      if (r[(last + 1 + off) % N]) return (last + 1 + off) % N;
    end
`else
    for (int unsigned i = 0; i < N; i++) begin
      if (r[i]) return i;
    end
`endif
    return 0;
  endfunction

  always @(posedge clk) begin : model
    int unsigned  c;
    logic [W-1:0] stp;
    c = cyc;
    if (!rst) begin
      m_act   = 0;
      sb.delete();
      m_last  = N - 1;
      m_free  = c + 1;
      m_data  = '0;
      started = 1;
    end else begin
      if (m_act) begin
        if (c >= m_t + 1 && c <= m_t + 2 + m_k && !req[m_w]) begin
          m_act  = 0;
          void'(sb.pop_back());
          m_last = m_w;
          m_free = c + 1;
        end else if (c == m_t + 3 + m_k) begin
          m_act  = 0;
          m_last = m_w;
        end
      end
      if (started && !m_act && c >= m_free && req != '0) begin
        m_w     = pick(req, m_last);
        m_start = start_val[m_w*W +: W];
        stp     = stop_val[m_w*W +: W];
        m_k     = (int'(stp) - int'(m_start) + 16) % 16;
        m_t     = c;
        m_act   = 1;
        m_data  = m_start;
        sb.push_back('{w: m_w, stop: stp, cyc: c + 3 + m_k});
        m_free  = c + 4 + m_k;
      end
    end
    cyc = c + 1;
  end

  always @(negedge clk) begin : monitor
    int unsigned n;
    bit          win, e_enb, e_modo;
    logic [N-1:0] eg;
    exp_t        e;
    if (started) begin
      n      = cyc;
      win    = m_act && n >= m_t + 1 && n <= m_t + 3 + m_k;
      eg     = win ? (N'(1) << m_w) : '0;
      e_enb  = 0;
      e_modo = 0;
      if (win && n == m_t + 1) begin
        e_enb  = req[m_w];
        e_modo = 1;
      end else if (win && n <= m_t + 2 + m_k) begin
        e_enb = req[m_w] && (n < m_t + 2 + m_k);
      end
      check("gnt", 32'(gnt), 32'(eg));
      check("busy", 32'(busy), 32'(win));
      check("cnt_enb", 32'(cnt_enb), 32'(e_enb));
      check("cnt_modo", 32'(cnt_modo), 32'(e_modo));
      check("cnt_data", 32'(cnt_data), 32'(m_data));
      if (m_act && n == m_t + 2) check("first_run_q", 32'(cnt_q), 32'(m_start));
      if (done != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_vec", 32'(done), 32'(1) << e.w);
          check("done_q", 32'(cnt_q), 32'(e.stop));
          check("done_cycle", n, e.cyc);
        end
      end else if (sb.size() > 0 && sb[0].cyc == n) begin
        check("done_missing", 32'(done), 32'(1) << sb[0].w);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_any_done(output int idx, output bit ok);
    idx = -1;
    ok  = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done != '0) begin
        for (int j = 0; j < N; j++) if (done[j]) idx = j;
        ok = 1;
        return;
      end
    end
    check("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_single(input int idx, input logic [W-1:0] s, input logic [W-1:0] p,
                            input int exp_lat);
    int lat;
    bit seen;
    start_val[idx*W +: W] = s;
    stop_val[idx*W +: W]  = p;
    req[idx] = 1'b1;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (done[idx]) seen = 1;
    end
    req[idx] = 1'b0;
    check("single_latency", 32'(lat), 32'(exp_lat));
    tick();
    check("single_hold_q", 32'(cnt_q), 32'(p));
  endtask

  initial begin : driver
    int  idx;
    bit  ok, seen;
    rst       = 1'b0;
    req       = '0;
    start_val = '0;
    stop_val  = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    run_single(0, 4'd3, 4'd7, 7);
    run_single(0, 4'd14, 4'd1, 6);
    run_single(0, 4'd5, 4'd5, 3);

    // Both held continuously after a reset
    rst = 1'b0;
    tick();
    rst       = 1'b1;
    start_val = {4'd2, 4'd2};
    stop_val  = {4'd4, 4'd4};
    req       = '1;
    for (int g = 0; g < 4; g++) begin
      wait_any_done(idx, ok);
`ifdef COUNTER_SEQ_ROUND_ROBIN_EN
      check("rr_grant", 32'(idx), 32'(g % 2));
`else
      check("fixed_grant", 32'(idx), 32'd0);
`endif
    end
    req = '0;
    repeat (2) tick();

    // Abort in the second RUN cycle
    start_val[0 +: W] = 4'd0;
    stop_val[0 +: W]  = 4'd10;
    req[0] = 1'b1;
    repeat (3) tick();
    req[0] = 1'b0;
    #1;
    check("abort_enb", 32'(cnt_enb), 32'd0);
    tick();
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (12) begin
      tick();
      if (done != '0) seen = 1;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    // Reset during RUN
    start_val = '0;
    stop_val  = {4'd12, 4'd12};
    req       = '1;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_outputs", {gnt, done, busy, cnt_enb, cnt_modo, cnt_data}, 32'd0);
    wait_any_done(idx, ok);
    check("post_reset_grant", 32'(idx), 32'd0);
    req = '0;
    repeat (3) tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (done[i] || (gnt[i] && $urandom_range(0, 49) == 0)) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
        end
      end
      start_val = SV_W'($urandom);
      stop_val  = SV_W'($urandom);
    end

    req = '0;
    rst = 1'b1;
    repeat (40) tick();
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Sequencer and arbiter for the shared 4-bit loadable counter datapath. Up to N_REQ requesters each ask for a count run from a start value to a stop value. The block grants one requester at a time, parallel-loads the counter with that requester's start value, and enables counting until the counter output equals the stop value. It then pulses `done` to the winner. It sits between the requester logic and the counter's `enb`/`modo`/`data`/`Q` pins.

## Interface
- `N_REQ`, 2, number of requesters (legal range 2..4)
- `CNT_W`, 4, counter width; must match the counter datapath
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-low
- `req`  in  N_REQ  request level per requester; held until `done` or dropped to abort
- `start_val`  in  N_REQ*CNT_W  packed start values; requester i at [i*CNT_W +: CNT_W]
- `stop_val`  in  N_REQ*CNT_W  packed stop values, same packing
- `gnt`  out  N_REQ  one-hot grant, registered
- `done`  out  N_REQ  one-cycle completion pulse to the winner, registered
- `busy`  out  1  high in any state other than IDLE
- `cnt_enb`  out  1  counter enable
- `cnt_modo`  out  1  counter mode: 1 = parallel load, 0 = count up
- `cnt_data`  out  CNT_W  counter parallel-load value, registered
- `cnt_q`  in  CNT_W  counter output Q

## Operation
- **States:** IDLE, LOAD, RUN, DONE.
- **IDLE**
  - `gnt` = 0 and `cnt_enb` = 0.
  - If any `req` bit is high, the arbiter picks a winner.
  - At that edge the block captures the winner index, `start_val[winner]` into `cnt_data`, and `stop_val[winner]` into `stop_reg`, then moves to LOAD.
- **LOAD** (exactly 1 cycle)
  - `cnt_enb` = 1, `cnt_modo` = 1.
  - Next state is RUN.
- **RUN**
  - `cnt_modo` = 0.
  - `cnt_enb` = (`cnt_q` != `stop_reg`); this is combinational from `cnt_q`.
  - When `cnt_q` == `stop_reg`, next state is DONE.
- **DONE** (1 cycle)
  - `done[winner]` = 1, `cnt_enb` = 0.
  - Round-robin pointer updates to the winner.
  - Next state is IDLE.
- **Grant window:** `gnt[winner]` is high from LOAD through DONE inclusive.
- **Wrap-around:** counting passes 15 -> 0 naturally. Run length in increments is k = (stop - start) mod 2^CNT_W.
- **start == stop:** equality holds on the first RUN cycle, so k = 0 and there are no count cycles.
- **Abort:** if `req[winner]` drops in LOAD or RUN, `cnt_enb` is forced to 0 in that cycle and the next state is IDLE. No `done` pulse is issued. The pointer still advances.
- **Request still high after DONE:** a `req` still high in the IDLE cycle after DONE is treated as a new request.
- **Counter reset is irrelevant:** the counter's own reset pin is never relied on, because every run starts with a load.

## Timing
- Reset (`rst` low at an edge):
  - state = IDLE; `gnt`, `done`, `busy`, `cnt_enb`, `cnt_modo` = 0; `cnt_data` = 0.
  - Pointer = requester 0 highest priority.
  - Reset mid-run aborts silently (no `done`).
- Cycle-level sequence, with `req` first sampled in IDLE at cycle t:
  - LOAD and `gnt` high at t+1.
  - `cnt_q` = start at t+2 (first RUN cycle).
  - `cnt_q` = stop at t+2+k.
  - DONE and `done` pulse at t+3+k.
  - IDLE at t+4+k.
- Total occupancy: k+3 cycles (LOAD, k+1 RUN cycles, DONE).
- Minimum gap between back-to-back grants: 1 IDLE cycle.
- `start_val`/`stop_val` are sampled only at the IDLE->LOAD edge; later changes are ignored.

## Configuration
- `COUNTER_SEQ_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration.
  - Search starts at (last_winner + 1) mod N_REQ.
  - Pointer register is present.
- `COUNTER_SEQ_ROUND_ROBIN_EN` undefined:
  - Fixed priority; the lowest requesting index always wins.
  - No pointer register.

## Structure
- Package `counter_seq_pkg`:
  - state encoding (IDLE, LOAD, RUN, DONE);
  - `MODO_COUNT` = 0, `MODO_LOAD` = 1;
  - default `CNT_W`.
- Sub-module `counter_seq_arb`:
  - combinational request-to-one-hot arbiter;
  - the pointer input is used only under the macro.
- FSM, capture registers and counter drive stay in the top.

## Test plan
- Single requester, start 3, stop 7 -> `gnt` at t+1, `cnt_enb` in RUN for 4 cycles, `done` at t+7, `cnt_q` = 7 at end.
- Wrap: start 14, stop 1 -> `cnt_q` sequence 14, 15, 0, 1; `done` at t+6.
- start = stop = 5 -> no count cycles; `done` at t+3; `cnt_q` stays 5.
- Both `req` held continuously, macro defined -> grants alternate 0, 1, 0, 1. Macro undefined -> requester 0 wins every time.
- `req[winner]` dropped in the second RUN cycle -> `cnt_enb` low that cycle, IDLE next, no `done`, `gnt` cleared.
- `rst` low during RUN -> all outputs 0 next cycle, no `done`; the next grant goes to requester 0.
